// File: rtl/bell_sequencer.sv
// Control FSM that prepares a Bell state: load |00>, apply H on q0, then CNOT(q0->q1),
// issuing each gate over a req/ack handshake with an ack timeout.
module bell_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_ack,
    output logic       gate_req,
    output logic [1:0] gate_op,
    output logic       reg_load,
    output logic       reg_init,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        ISSUE_H  = 3'd2,
        LOAD_H   = 3'd3,
        ISSUE_CX = 3'd4,
        LOAD_CX  = 3'd5,
        DONE     = 3'd6,
        ERROR    = 3'd7
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_H   = 2'b01;
    localparam logic [1:0] OP_CX  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             issuing;
    logic             timed_out;

    assign issuing   = (state == ISSUE_H) || (state == ISSUE_CX);
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter is zero whenever not waiting, so every ISSUE state is entered with a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (issuing && !gate_ack && !abort) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (start) state_next = INIT;
                INIT:     state_next = ISSUE_H;
                ISSUE_H: begin
                    if (gate_ack)       state_next = LOAD_H;
                    else if (timed_out) state_next = ERROR;
                end
                LOAD_H:   state_next = ISSUE_CX;
                ISSUE_CX: begin
                    if (gate_ack)       state_next = LOAD_CX;
                    else if (timed_out) state_next = ERROR;
                end
                LOAD_CX:  state_next = DONE;
                DONE:     state_next = IDLE;
                ERROR:    if (start) state_next = INIT;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        gate_req  = 1'b0;
        gate_op   = OP_NOP;
        reg_load  = 1'b0;
        reg_init  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        state_dbg = state;
        unique case (state)
            IDLE: ;
            INIT: begin
                reg_load = 1'b1;
                reg_init = 1'b1;
                busy     = 1'b1;
            end
            ISSUE_H: begin
                gate_req = 1'b1;
                gate_op  = OP_H;
                busy     = 1'b1;
            end
            LOAD_H: begin
                gate_op  = OP_H;
                reg_load = 1'b1;
                busy     = 1'b1;
            end
            ISSUE_CX: begin
                gate_req = 1'b1;
                gate_op  = OP_CX;
                busy     = 1'b1;
            end
            LOAD_CX: begin
                gate_op  = OP_CX;
                reg_load = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ERROR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bell_sequencer.sv
// Directed vector bench for bell_sequencer: per-cycle inputs with the expected Moore outputs
// of the state occupied during that cycle.
module tb_bell_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, gate_ack;
    logic       gate_req, reg_load, reg_init, busy, done, err;
    logic [1:0] gate_op;
    logic [2:0] state_dbg;

    bell_sequencer #(.ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .gate_ack  (gate_ack),
        .gate_req  (gate_req),
        .gate_op   (gate_op),
        .reg_load  (reg_load),
        .reg_init  (reg_init),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Output bundle: {gate_req, gate_op[1:0], reg_load, reg_init, busy, done, err, state_dbg[2:0]}
    localparam logic [10:0] O_IDLE = 11'b0_00_0_0_0_0_0_000;
    localparam logic [10:0] O_INIT = 11'b0_00_1_1_1_0_0_001;
    localparam logic [10:0] O_ISSH = 11'b1_01_0_0_1_0_0_010;
    localparam logic [10:0] O_LDH  = 11'b0_01_1_0_1_0_0_011;
    localparam logic [10:0] O_ISCX = 11'b1_10_0_0_1_0_0_100;
    localparam logic [10:0] O_LDCX = 11'b0_10_1_0_1_0_0_101;
    localparam logic [10:0] O_DONE = 11'b0_00_0_0_1_1_0_110;
    localparam logic [10:0] O_ERR  = 11'b0_00_0_0_0_0_1_111;

    typedef struct {
        logic        start;
        logic        abort;
        logic        ack;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic logic [10:0] outs();
        return {gate_req, gate_op, reg_load, reg_init, busy, done, err, state_dbg};
    endfunction

    task automatic add(input logic s, input logic a, input logic k, input logic [10:0] e);
        vec_t v;
        v.start = s;
        v.abort = a;
        v.ack   = k;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = outs();
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    initial begin
        // Immediate ack: INIT at 1, loads at 1/3/5, done at 6, IDLE at 7.
        add(1, 0, 1, O_IDLE);
        add(0, 0, 1, O_INIT);
        add(0, 0, 1, O_ISSH);
        add(0, 0, 1, O_LDH);
        add(0, 0, 1, O_ISCX);
        add(0, 0, 1, O_LDCX);
        add(0, 0, 1, O_DONE);
        add(0, 0, 0, O_IDLE);

        // Three-cycle ack delay per gate, stray start while busy: done at cycle 12.
        add(1, 0, 0, O_IDLE);
        add(0, 0, 0, O_INIT);
        add(0, 0, 0, O_ISSH);
        add(1, 0, 0, O_ISSH);
        add(0, 0, 0, O_ISSH);
        add(0, 0, 1, O_ISSH);
        add(0, 0, 0, O_LDH);
        add(0, 0, 0, O_ISCX);
        add(1, 0, 0, O_ISCX);
        add(0, 0, 0, O_ISCX);
        add(0, 0, 1, O_ISCX);
        add(1, 0, 0, O_LDCX);
        add(1, 0, 0, O_DONE);
        add(0, 0, 0, O_IDLE);

        // No ack at all: ERROR after exactly 15 req cycles, no LOAD_H.
        add(1, 0, 0, O_IDLE);
        add(0, 0, 0, O_INIT);
        for (int i = 0; i < 15; i++) add(0, 0, 0, O_ISSH);
        add(0, 0, 1, O_ERR);
        add(0, 0, 0, O_ERR);
        add(1, 0, 0, O_ERR);

        // Restart from ERROR; ack on the 15th req cycle of each gate still proceeds.
        add(0, 0, 0, O_INIT);
        for (int i = 0; i < 14; i++) add(0, 0, 0, O_ISSH);
        add(0, 0, 1, O_ISSH);
        add(0, 0, 0, O_LDH);
        for (int i = 0; i < 14; i++) add(0, 0, 0, O_ISCX);
        add(0, 0, 1, O_ISCX);
        add(0, 0, 0, O_LDCX);
        add(0, 0, 0, O_DONE);
        add(0, 0, 0, O_IDLE);

        // Abort with ack present in ISSUE_CX, then start+abort together in IDLE.
        add(1, 0, 0, O_IDLE);
        add(0, 0, 0, O_INIT);
        add(0, 0, 1, O_ISSH);
        add(0, 0, 0, O_LDH);
        add(0, 1, 1, O_ISCX);
        add(1, 1, 0, O_IDLE);
        add(0, 0, 1, O_IDLE);
        add(0, 0, 0, O_IDLE);

        // Abort clears ERROR.
        add(1, 0, 0, O_IDLE);
        add(0, 0, 0, O_INIT);
        for (int i = 0; i < 15; i++) add(0, 0, 0, O_ISSH);
        add(0, 1, 0, O_ERR);
        add(0, 0, 0, O_IDLE);

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        gate_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset", O_IDLE);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            start    = vecs[i].start;
            abort    = vecs[i].abort;
            gate_ack = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset in the middle of ISSUE_H.
        @(posedge clk); #1 start = 1'b1; abort = 1'b0; gate_ack = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk) check("mid_init", O_INIT);
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk) check("mid_issh", O_ISSH);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check("async_rst", O_IDLE);
        @(negedge clk) begin
            rst_n = 1'b1;
            start = 1'b0;
        end
        @(posedge clk); #1 check("post_rst", O_IDLE);

        // Fresh sequence after reset also gets a full timeout window.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk) check("rst_init", O_INIT);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk) check($sformatf("rst_wait%0d", i), O_ISSH);
        end
        @(posedge clk);
        @(negedge clk) check("rst_err", O_ERR);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
